// File: rtl/aes_key_schedule_seq.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_schedule_seq
//  Purpose  : Sequential AES key expansion. One 32-bit schedule word is
//             produced per clock through a single shared SubWord unit; all
//             round keys are kept in an internal word buffer and served one
//             128-bit round key per request over a registered read port.
//  Ports    : clk, rst (async, active-high)
//             key_load / seed_key   : start (or restart) expansion
//             busy / key_ready      : expansion status
//             rk_req / rk_index     : round-key read request
//             rk_valid / rk_err / rk_data : registered read response
//  Options  : AES_KS_EARLY_READ_EN - allow reads of round keys whose words
//             are already committed while expansion is still running.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_key_schedule_seq #(
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_load,
    input  logic [KEY_WORDS*32-1:0] seed_key,
    output logic                    busy,
    output logic                    key_ready,
    input  logic                    rk_req,
    input  logic [3:0]              rk_index,
    output logic                    rk_valid,
    output logic                    rk_err,
    output logic [127:0]            rk_data
);

    localparam int c_NW = 4 * (ROUNDS + 1);
    localparam int c_AW = $clog2(c_NW);
    localparam int c_CW = $clog2(c_NW + 1);
    localparam int c_PW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

    // Forward S-box, entry 0 in the MSBs.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox[(255 - int'(b)) * 8 +: 8];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_w [c_NW];
    logic [c_CW-1:0]  r_cnt;      // index i of the next word to generate
    logic [c_PW-1:0]  r_phase;    // i % KEY_WORDS, tracked incrementally
    logic [7:0]       r_rcon;

    logic [c_AW-1:0]  w_cur_idx;
    logic [c_AW-1:0]  w_prev_idx;
    logic [c_AW-1:0]  w_back_idx;
    logic [31:0]      w_prev;
    logic [31:0]      w_sub_in;
    logic [31:0]      w_sub_out;
    logic [31:0]      w_t;
    logic [31:0]      w_new;
    logic             w_last;
    logic             w_rd_ok;
    logic [127:0]     w_rd_data;

    assign w_cur_idx  = c_AW'(r_cnt);
    assign w_prev_idx = c_AW'(r_cnt - c_CW'(1));
    assign w_back_idx = c_AW'(r_cnt - c_CW'(KEY_WORDS));
    assign w_prev     = r_w[w_prev_idx];
    assign w_last     = (int'(r_cnt) == c_NW - 1);

    // Single SubWord unit: its input is RotWord'ed only on the rcon phase.
    assign w_sub_in  = (r_phase == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sub_out = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                        sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};

    always_comb begin
        w_t = w_prev;
        if (r_phase == '0) begin
            w_t = w_sub_out ^ {r_rcon, 24'h0};
        end else if ((KEY_WORDS > 6) && (int'(r_phase) == 4)) begin
            w_t = w_sub_out;
        end
    end

    assign w_new = r_w[w_back_idx] ^ w_t;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (key_load) begin
            w_state_nxt = S_EXPAND;
        end else if ((r_state == S_EXPAND) && w_last) begin
            w_state_nxt = S_READY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_phase <= '0;
            r_rcon  <= 8'h01;
        end else begin
            r_state <= w_state_nxt;
            if (key_load) begin
                r_cnt   <= c_CW'(KEY_WORDS);
                r_phase <= '0;
                r_rcon  <= 8'h01;
            end else if (r_state == S_EXPAND) begin
                r_cnt   <= r_cnt + c_CW'(1);
                r_phase <= (int'(r_phase) == KEY_WORDS - 1) ? '0 : r_phase + c_PW'(1);
                if (r_phase == '0) begin
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
            end
        end
    end

    assign busy      = (r_state == S_EXPAND);
    assign key_ready = (r_state == S_READY);

    // Word buffer: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (key_load) begin
            for (int k = 0; k < KEY_WORDS; k++) begin
                r_w[k] <= seed_key[(KEY_WORDS - 1 - k) * 32 +: 32];
            end
        end else if (r_state == S_EXPAND) begin
            r_w[w_cur_idx] <= w_new;
        end
    end

    // ------------------------------------------------------------------
    // Read port. A load on the same edge always wins over the read.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        for (int j = 0; j < 4; j++) begin
            w_rd_data[127 - 32 * j -: 32] = r_w[c_AW'(int'(rk_index) * 4 + j)];
        end
`ifdef AES_KS_EARLY_READ_EN
        // The last word of the key may be the one being written this edge.
        if ((r_state == S_EXPAND) && (int'(r_cnt) == int'(rk_index) * 4 + 3)) begin
            w_rd_data[31:0] = w_new;
        end
        w_rd_ok = !key_load && (int'(rk_index) <= ROUNDS) &&
                  ((r_state == S_READY) ||
                   ((r_state == S_EXPAND) && (int'(r_cnt) >= int'(rk_index) * 4 + 3)));
`else
        w_rd_ok = !key_load && (r_state == S_READY) && (int'(rk_index) <= ROUNDS);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
            rk_data  <= '0;
        end else begin
            rk_valid <= rk_req;
            rk_err   <= rk_req && !w_rd_ok;
            if (rk_req) begin
                rk_data <= w_rd_ok ? w_rd_data : '0;
            end
        end
    end

endmodule
`default_nettype wire
